// File: rtl/cmd_frame_rx_if.sv
// Result bus of cmd_frame_rx: parameter-RAM write port, command commit and status pulses.
interface cmd_frame_rx_if #(
    parameter int unsigned ADDR_W = 5
);
    logic              param_we;
    logic [ADDR_W-1:0] param_waddr;
    logic [7:0]        param_wdata;
    logic              cmd_valid;
    logic [7:0]        cmd_len;
    logic [7:0]        cmd_tc_cntr;
    logic              err_frame;
    logic              err_chksum;
    logic              err_len;
    logic              err_timeout;
    logic              dup_drop;
    logic              busy;

    modport master (
        output param_we, param_waddr, param_wdata, cmd_valid, cmd_len, cmd_tc_cntr,
               err_frame, err_chksum, err_len, err_timeout, dup_drop, busy
    );

    modport slave (
        input  param_we, param_waddr, param_wdata, cmd_valid, cmd_len, cmd_tc_cntr,
               err_frame, err_chksum, err_len, err_timeout, dup_drop, busy
    );
endinterface

// File: rtl/cmd_frame_rx.sv
// RS485 command frame receiver: mid-bit UART byte receiver feeding a
// SYNC/TC/LEN/PID/params/XOR-checksum parser that writes the parameter RAM.
module cmd_frame_rx #(
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned MAX_PARAMS   = 29,
    parameter int unsigned CNT_W        = 8,
    parameter logic [7:0]  SYNC_BYTE    = 8'hFC,
    parameter logic [7:0]  BCAST_ID     = 8'hFF,
    parameter int unsigned TIMEOUT_BITS = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx,
    input  logic [7:0]       payload_id,
    input  logic [CNT_W-1:0] clk_per_bit,
    cmd_frame_rx_if.master   bus
);
    localparam int unsigned TO_W    = CNT_W + 5;
    localparam logic [7:0]  MAX_LEN = 8'(MAX_PARAMS);

    typedef enum logic [1:0] {BR_IDLE, BR_START, BR_DATA, BR_STOP} br_state_e;
    typedef enum logic [2:0] {P_HUNT, P_TC, P_LEN, P_PID, P_PARAM, P_CHK} p_state_e;

    logic             rx_meta_q, rx_sync_q;
    br_state_e        br_state_q, br_state_d;
    logic [CNT_W-1:0] cpb_q, cpb_d, bcnt_q, bcnt_d;
    logic [CNT_W-1:0] half_c, last_c;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             byte_done_c, stop_err_c;

    p_state_e         p_state_q, p_state_d;
    logic [7:0]       tc_q, tc_d, len_q, len_d, chk_q, chk_d, idx_q, idx_d;
    logic             match_q, match_d;
    logic [7:0]       last_tc_q, last_tc_d;
    logic             last_tc_vld_q, last_tc_vld_d;
    logic [TO_W-1:0]  to_q, to_d, to_limit_c;

    logic              param_we_q, param_we_d;
    logic [ADDR_W-1:0] param_waddr_q, param_waddr_d;
    logic [7:0]        param_wdata_q, param_wdata_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic [7:0]        cmd_len_q, cmd_len_d, cmd_tc_cntr_q, cmd_tc_cntr_d;
    logic              err_frame_q, err_frame_d, err_chksum_q, err_chksum_d;
    logic              err_len_q, err_len_d, err_timeout_q, err_timeout_d;
    logic              dup_drop_q, dup_drop_d, busy_q, busy_d;

    assign half_c = (cpb_q - CNT_W'(1)) >> 1;
    assign last_c = cpb_q - CNT_W'(1);

    // Byte receiver: start-bit qualify at half period, then one sample per bit period.
    always_comb begin
        br_state_d  = br_state_q;
        cpb_d       = cpb_q;
        bcnt_d      = bcnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        byte_done_c = 1'b0;
        stop_err_c  = 1'b0;
        unique case (br_state_q)
            BR_IDLE: begin
                if (!rx_sync_q) begin
                    br_state_d = BR_START;
                    cpb_d      = clk_per_bit;
                    bcnt_d     = '0;
                end
            end
            BR_START: begin
                if (bcnt_q == half_c) begin
                    bcnt_d     = '0;
                    bit_idx_d  = '0;
                    br_state_d = rx_sync_q ? BR_IDLE : BR_DATA;
                end else begin
                    bcnt_d = bcnt_q + CNT_W'(1);
                end
            end
            BR_DATA: begin
                if (bcnt_q == last_c) begin
                    bcnt_d  = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) br_state_d = BR_STOP;
                    else                   bit_idx_d  = bit_idx_q + 3'd1;
                end else begin
                    bcnt_d = bcnt_q + CNT_W'(1);
                end
            end
            BR_STOP: begin
                if (bcnt_q == last_c) begin
                    br_state_d  = BR_IDLE;
                    byte_done_c = rx_sync_q;
                    stop_err_c  = !rx_sync_q;
                end else begin
                    bcnt_d = bcnt_q + CNT_W'(1);
                end
            end
            default: br_state_d = BR_IDLE;
        endcase
    end

    // Frame parser, inter-byte timeout and registered result outputs.
    always_comb begin
        p_state_d     = p_state_q;
        tc_d          = tc_q;
        len_d         = len_q;
        chk_d         = chk_q;
        idx_d         = idx_q;
        match_d       = match_q;
        last_tc_d     = last_tc_q;
        last_tc_vld_d = last_tc_vld_q;
        param_we_d    = 1'b0;
        param_waddr_d = param_waddr_q;
        param_wdata_d = param_wdata_q;
        cmd_valid_d   = 1'b0;
        cmd_len_d     = cmd_len_q;
        cmd_tc_cntr_d = cmd_tc_cntr_q;
        err_frame_d   = 1'b0;
        err_chksum_d  = 1'b0;
        err_len_d     = 1'b0;
        err_timeout_d = 1'b0;
        dup_drop_d    = 1'b0;
        to_limit_c    = TO_W'(TIMEOUT_BITS) * TO_W'(cpb_q);

        if (p_state_q == P_HUNT || br_state_q != BR_IDLE) to_d = '0;
        else if (to_q != '1)                              to_d = to_q + TO_W'(1);
        else                                              to_d = to_q;

        if (stop_err_c) begin
            err_frame_d = 1'b1;
            p_state_d   = P_HUNT;
        end else if (p_state_q != P_HUNT && br_state_q == BR_IDLE && to_q >= to_limit_c) begin
            err_timeout_d = 1'b1;
            p_state_d     = P_HUNT;
        end else if (byte_done_c) begin
            unique case (p_state_q)
                P_HUNT: begin
                    if (shift_q == SYNC_BYTE) p_state_d = P_TC;
                end
                P_TC: begin
                    tc_d      = shift_q;
                    chk_d     = shift_q;
                    p_state_d = P_LEN;
                end
                P_LEN: begin
                    if (shift_q > MAX_LEN) begin
                        err_len_d = 1'b1;
                        p_state_d = P_HUNT;
                    end else begin
                        len_d     = shift_q;
                        chk_d     = chk_q ^ shift_q;
                        p_state_d = P_PID;
                    end
                end
                P_PID: begin
                    match_d   = (shift_q == payload_id) || (shift_q == BCAST_ID);
                    chk_d     = chk_q ^ shift_q;
                    idx_d     = '0;
                    p_state_d = (len_q != 8'd0) ? P_PARAM : P_CHK;
                end
                P_PARAM: begin
                    chk_d         = chk_q ^ shift_q;
                    param_we_d    = match_q;
                    param_waddr_d = idx_q[ADDR_W-1:0];
                    param_wdata_d = shift_q;
                    idx_d         = idx_q + 8'd1;
                    if (idx_q == len_q - 8'd1) p_state_d = P_CHK;
                end
                P_CHK: begin
                    p_state_d = P_HUNT;
                    if (shift_q != chk_q) begin
                        err_chksum_d = 1'b1;
                    end else if (match_q) begin
                        if (last_tc_vld_q && tc_q == last_tc_q) begin
                            dup_drop_d = 1'b1;
                        end else begin
                            cmd_valid_d   = 1'b1;
                            cmd_len_d     = len_q;
                            cmd_tc_cntr_d = tc_q;
                            last_tc_d     = tc_q;
                            last_tc_vld_d = 1'b1;
                        end
                    end
                end
                default: p_state_d = P_HUNT;
            endcase
        end

        busy_d = (p_state_d != P_HUNT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q     <= 1'b1;
            rx_sync_q     <= 1'b1;
            br_state_q    <= BR_IDLE;
            cpb_q         <= '0;
            bcnt_q        <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            p_state_q     <= P_HUNT;
            tc_q          <= '0;
            len_q         <= '0;
            chk_q         <= '0;
            idx_q         <= '0;
            match_q       <= 1'b0;
            last_tc_q     <= '0;
            last_tc_vld_q <= 1'b0;
            to_q          <= '0;
            param_we_q    <= 1'b0;
            param_waddr_q <= '0;
            param_wdata_q <= '0;
            cmd_valid_q   <= 1'b0;
            cmd_len_q     <= '0;
            cmd_tc_cntr_q <= '0;
            err_frame_q   <= 1'b0;
            err_chksum_q  <= 1'b0;
            err_len_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            dup_drop_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            rx_meta_q     <= rx;
            rx_sync_q     <= rx_meta_q;
            br_state_q    <= br_state_d;
            cpb_q         <= cpb_d;
            bcnt_q        <= bcnt_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            p_state_q     <= p_state_d;
            tc_q          <= tc_d;
            len_q         <= len_d;
            chk_q         <= chk_d;
            idx_q         <= idx_d;
            match_q       <= match_d;
            last_tc_q     <= last_tc_d;
            last_tc_vld_q <= last_tc_vld_d;
            to_q          <= to_d;
            param_we_q    <= param_we_d;
            param_waddr_q <= param_waddr_d;
            param_wdata_q <= param_wdata_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_len_q     <= cmd_len_d;
            cmd_tc_cntr_q <= cmd_tc_cntr_d;
            err_frame_q   <= err_frame_d;
            err_chksum_q  <= err_chksum_d;
            err_len_q     <= err_len_d;
            err_timeout_q <= err_timeout_d;
            dup_drop_q    <= dup_drop_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.param_we    = param_we_q;
    assign bus.param_waddr = param_waddr_q;
    assign bus.param_wdata = param_wdata_q;
    assign bus.cmd_valid   = cmd_valid_q;
    assign bus.cmd_len     = cmd_len_q;
    assign bus.cmd_tc_cntr = cmd_tc_cntr_q;
    assign bus.err_frame   = err_frame_q;
    assign bus.err_chksum  = err_chksum_q;
    assign bus.err_len     = err_len_q;
    assign bus.err_timeout = err_timeout_q;
    assign bus.dup_drop    = dup_drop_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_cmd_frame_rx.sv
// Self-checking bench for cmd_frame_rx: directed frames plus random frames
// checked against a frame-level outcome model.
module tb_cmd_frame_rx;
    localparam int unsigned ADDR_W       = 5;
    localparam int unsigned MAX_PARAMS   = 29;
    localparam int unsigned CNT_W        = 8;
    localparam int unsigned TIMEOUT_BITS = 20;
    localparam logic [7:0]  NODE_ID      = 8'h01;

    logic             clk = 1'b0;
    logic             reset;
    logic             rx;
    logic [7:0]       payload_id;
    logic [CNT_W-1:0] clk_per_bit;

    cmd_frame_rx_if #(.ADDR_W(ADDR_W)) bus ();

    cmd_frame_rx #(
        .ADDR_W(ADDR_W), .MAX_PARAMS(MAX_PARAMS), .CNT_W(CNT_W),
        .SYNC_BYTE(8'hFC), .BCAST_ID(8'hFF), .TIMEOUT_BITS(TIMEOUT_BITS)
    ) dut (
        .clk(clk), .reset(reset), .rx(rx), .payload_id(payload_id),
        .clk_per_bit(clk_per_bit), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cpb     = 8;

    // Frame-level model state
    logic [7:0] m_last_tc  = 8'h00;
    logic       m_last_vld = 1'b0;
    logic [7:0] m_cmd_len  = 8'h00;
    logic [7:0] m_cmd_tc   = 8'h00;
    logic [7:0] prm [40];

    // Event log filled by the monitor, read by index from the stimulus thread
    int tot_valid = 0, tot_dup = 0, tot_ef = 0, tot_ec = 0, tot_el = 0, tot_et = 0;
    logic [ADDR_W-1:0] wr_addr_log [$];
    logic [7:0]        wr_data_log [$];

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.param_we) begin
                wr_addr_log.push_back(bus.param_waddr);
                wr_data_log.push_back(bus.param_wdata);
            end
            if (bus.cmd_valid)   tot_valid++;
            if (bus.dup_drop)    tot_dup++;
            if (bus.err_frame)   tot_ef++;
            if (bus.err_chksum)  tot_ec++;
            if (bus.err_len)     tot_el++;
            if (bus.err_timeout) tot_et++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (cpb) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
    endtask

    // Send one frame built from prm[], then compare every observable against the model
    task automatic run_frame(input string tag, input logic [7:0] tc, input logic [7:0] len,
                             input logic [7:0] pid, input logic [7:0] chk_flip,
                             input int bit_clks, input logic glitch);
        int         wr_base, v0, d0, ef0, ec0, el0, et0, n_wr, exp_wr;
        logic [7:0] sum;
        logic       len_bad, match, exp_ck, exp_dup, exp_val;
        wr_base = wr_addr_log.size();
        v0 = tot_valid; d0 = tot_dup; ef0 = tot_ef; ec0 = tot_ec; el0 = tot_el; et0 = tot_et;
        cpb = bit_clks;
        clk_per_bit = CNT_W'(bit_clks);
        len_bad = (32'(len) > MAX_PARAMS);
        send_byte(8'hFC, 1'b1);
        send_byte(tc, 1'b1);
        send_byte(len, 1'b1);
        if (!len_bad) begin
            if (glitch) begin
                rx = 1'b0;
                repeat (2) @(negedge clk);
                rx = 1'b1;
                repeat (3 * cpb) @(negedge clk);
            end
            send_byte(pid, 1'b1);
            sum = tc ^ len ^ pid;
            for (int i = 0; i < int'(len); i++) begin
                send_byte(prm[i], 1'b1);
                sum = sum ^ prm[i];
            end
            send_byte(sum ^ chk_flip, 1'b1);
        end
        rx = 1'b1;
        repeat (cpb + 4) @(negedge clk);

        match   = (pid == NODE_ID) || (pid == 8'hFF);
        exp_wr  = (!len_bad && match) ? int'(len) : 0;
        exp_ck  = !len_bad && (chk_flip != 8'h00);
        exp_dup = !len_bad && !exp_ck && match && m_last_vld && (tc == m_last_tc);
        exp_val = !len_bad && !exp_ck && match && !exp_dup;
        if (exp_val) begin
            m_last_tc  = tc;
            m_last_vld = 1'b1;
            m_cmd_len  = len;
            m_cmd_tc   = tc;
        end

        n_wr = wr_addr_log.size() - wr_base;
        check_eq({tag, " n_writes"}, 32'(n_wr), 32'(exp_wr));
        for (int i = 0; i < exp_wr && i < n_wr; i++) begin
            check_eq($sformatf("%s waddr%0d", tag, i), 32'(wr_addr_log[wr_base + i]), 32'(i));
            check_eq($sformatf("%s wdata%0d", tag, i), 32'(wr_data_log[wr_base + i]), 32'(prm[i]));
        end
        check_eq({tag, " cmd_valid"},   32'(tot_valid - v0), 32'(exp_val));
        check_eq({tag, " dup_drop"},    32'(tot_dup - d0),   32'(exp_dup));
        check_eq({tag, " err_chksum"},  32'(tot_ec - ec0),   32'(exp_ck));
        check_eq({tag, " err_len"},     32'(tot_el - el0),   32'(len_bad));
        check_eq({tag, " err_frame"},   32'(tot_ef - ef0),   32'(0));
        check_eq({tag, " err_timeout"}, 32'(tot_et - et0),   32'(0));
        check_eq({tag, " cmd_len"},     32'(bus.cmd_len),     32'(m_cmd_len));
        check_eq({tag, " cmd_tc"},      32'(bus.cmd_tc_cntr), 32'(m_cmd_tc));
        check_eq({tag, " busy"},        32'(bus.busy),        32'(0));
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, " wr bus"}, 32'({bus.param_we, bus.param_waddr, bus.param_wdata}), 32'(0));
        check_eq({tag, " cmd"},    32'({bus.cmd_valid, bus.cmd_len, bus.cmd_tc_cntr}), 32'(0));
        check_eq({tag, " flags"},  32'({bus.err_frame, bus.err_chksum, bus.err_len,
                                        bus.err_timeout, bus.dup_drop, bus.busy}), 32'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int ef0, et0, v0, w0, r;
        logic [7:0] tc, len, pid, flip;
        reset       = 1'b1;
        rx          = 1'b1;
        payload_id  = NODE_ID;
        clk_per_bit = CNT_W'(8);
        for (int i = 0; i < 40; i++) prm[i] = 8'($urandom);
        repeat (4) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        repeat (4) @(negedge clk);

        prm[0] = 8'hAA; prm[1] = 8'h55;
        run_frame("first",     8'h05, 8'd2, 8'h01, 8'h00, 8, 1'b0);
        run_frame("dup",       8'h05, 8'd2, 8'h01, 8'h00, 8, 1'b0);
        run_frame("tc06",      8'h06, 8'd2, 8'h01, 8'h00, 8, 1'b0);
        run_frame("other_id",  8'h07, 8'd2, 8'h03, 8'h00, 8, 1'b0);
        run_frame("bcast",     8'h07, 8'd2, 8'hFF, 8'h00, 8, 1'b0);
        run_frame("chk_zero",  8'h05, 8'd2, 8'h01, 8'hF9, 8, 1'b0);
        run_frame("len30",     8'h08, 8'd30, 8'h01, 8'h00, 8, 1'b0);
        run_frame("len0",      8'h09, 8'd0, 8'h01, 8'h00, 8, 1'b0);
        for (int i = 0; i < 40; i++) prm[i] = 8'($urandom);
        run_frame("len29",     8'h0A, 8'd29, 8'h01, 8'h00, 6, 1'b0);

        // Stop bit low on LEN byte
        ef0 = tot_ef; v0 = tot_valid;
        cpb = 8; clk_per_bit = CNT_W'(8);
        send_byte(8'hFC, 1'b1);
        send_byte(8'h0B, 1'b1);
        send_byte(8'h02, 1'b0);
        rx = 1'b1;
        repeat (15 * cpb) @(negedge clk);
        check_eq("stop0 err_frame", 32'(tot_ef - ef0), 32'(1));
        check_eq("stop0 busy", 32'(bus.busy), 32'(0));
        check_eq("stop0 cmd_valid", 32'(tot_valid - v0), 32'(0));
        run_frame("after_stop0", 8'h0C, 8'd3, 8'h01, 8'h00, 8, 1'b0);

        run_frame("glitch16", 8'h0D, 8'd4, 8'h01, 8'h00, 16, 1'b1);

        // Stream halted after PID
        et0 = tot_et; v0 = tot_valid; w0 = wr_addr_log.size();
        cpb = 8; clk_per_bit = CNT_W'(8);
        send_byte(8'hFC, 1'b1);
        send_byte(8'h0E, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h01, 1'b1);
        repeat (10 * cpb) @(negedge clk);
        check_eq("to early pulse", 32'(tot_et - et0), 32'(0));
        check_eq("to early busy", 32'(bus.busy), 32'(1));
        repeat (10 * cpb + 2) @(negedge clk);
        check_eq("to pulse", 32'(tot_et - et0), 32'(1));
        check_eq("to busy", 32'(bus.busy), 32'(0));
        check_eq("to writes", 32'(wr_addr_log.size() - w0), 32'(0));
        check_eq("to cmd_valid", 32'(tot_valid - v0), 32'(0));

        // Reset in the middle of the parameter bytes
        send_byte(8'hFC, 1'b1);
        send_byte(8'h0F, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h11, 1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        check_eq("mid busy", 32'(bus.busy), 32'(1));
        reset = 1'b1;
        rx    = 1'b1;
        @(negedge clk);
        check_all_zero("mid_reset");
        reset = 1'b0;
        m_last_vld = 1'b0;
        m_last_tc  = 8'h00;
        m_cmd_len  = 8'h00;
        m_cmd_tc   = 8'h00;
        repeat (4) @(negedge clk);
        prm[0] = 8'hAA; prm[1] = 8'h55;
        run_frame("post_reset", 8'h05, 8'd2, 8'h01, 8'h00, 8, 1'b0);

        for (int f = 0; f < 10; f++) begin
            for (int i = 0; i < 40; i++) prm[i] = 8'($urandom);
            r   = $urandom_range(3, 0);
            tc  = (r == 0 && m_last_vld) ? m_last_tc : 8'($urandom);
            r   = $urandom_range(9, 0);
            len = (r == 0) ? 8'($urandom_range(40, 30)) : 8'($urandom_range(MAX_PARAMS, 0));
            r   = $urandom_range(3, 0);
            pid = (r < 2) ? NODE_ID : ((r == 2) ? 8'hFF : 8'($urandom));
            flip = ($urandom_range(4, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
            run_frame($sformatf("rnd%0d", f), tc, len, pid, flip, $urandom_range(12, 4), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
